// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: command record and FSM states.
package alu_seq_pkg;

    localparam int unsigned ALU_SEL_W = 3;
    localparam int unsigned CMD_N     = 32;

    typedef struct packed {
        logic [CMD_N-1:0]     a;
        logic [CMD_N-1:0]     b;
        logic [ALU_SEL_W-1:0] sel;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so the pointers wrap naturally.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  alu_cmd_t               wdata_i,
    output alu_cmd_t               rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Push is gated on the registered full flag, so a same-cycle pop never frees a slot.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues them one at a time to a clocked ALU, and holds
// each result in a response register until the consumer takes it.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [N-1:0]           cmd_a,
    input  logic [N-1:0]           cmd_b,
    input  logic [2:0]             cmd_sel,
    output logic [N-1:0]           alu_a,
    output logic [N-1:0]           alu_b,
    output logic [2:0]             alu_sel,
    input  logic [N-1:0]           alu_out,
    input  logic                   alu_carry,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [N-1:0]           rsp_data,
    output logic                   rsp_carry,
    output logic [2:0]             rsp_sel,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(ALU_LAT + 1);

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [2:0]     alu_sel_q, alu_sel_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic [2:0]     rsp_sel_q, rsp_sel_d;

    alu_cmd_t       fifo_wdata;
    alu_cmd_t       fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;

    assign cmd_ready = rst_n && !fifo_full;

    always_comb begin
        fifo_wdata     = '0;
        fifo_wdata.a   = CMD_N'(cmd_a);
        fifo_wdata.b   = CMD_N'(cmd_b);
        fifo_wdata.sel = cmd_sel;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_sel_d   = rsp_sel_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // IDLE and HOLD share the issue path: any pop loads the ALU operands.
        if (fifo_pop) begin
            alu_a_d   = N'(fifo_rdata.a);
            alu_b_d   = N'(fifo_rdata.b);
            alu_sel_d = fifo_rdata.sel;
            rsp_sel_d = fifo_rdata.sel;
            cnt_d     = CW'(ALU_LAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_sel_q   <= rsp_sel_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_sel   = rsp_sel_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer directly upstream of the clocked `alu`. It accepts ALU commands {A, B, select} over a valid/ready handshake into a small FIFO and issues them one at a time on the ALU's registered operand inputs. It waits the ALU's pipeline latency, then captures `ALU_out`/`Carry_out` into a response register offered downstream over a second valid/ready handshake. It decouples the command producer and the result consumer from the ALU's fixed timing.

## Interface
Parameters:
- `N`, 32, operand/result width; matches the ALU's `n`.
- `DEPTH`, 4, command FIFO entries; must be a power of two, ≥2.
- `ALU_LAT`, 1, cycles from the ALU sampling its operands to `ALU_out` being valid; must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  `!full`; forced 0 while `rst_n` is low.
- `cmd_a`  in  N  operand A.
- `cmd_b`  in  N  operand B.
- `cmd_sel`  in  3  ALU select.
- `alu_a`  out  N  registered operand A to ALU `A`.
- `alu_b`  out  N  registered operand B to ALU `B`.
- `alu_sel`  out  3  registered select to ALU `ALU_sel`.
- `alu_out`  in  N  from ALU `ALU_out`.
- `alu_carry`  in  1  from ALU `Carry_out`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  N  captured result.
- `rsp_carry`  out  1  captured carry.
- `rsp_sel`  out  3  select of the op that produced the response.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push occurs when `cmd_valid && cmd_ready`. Pop is internal, driven by the FSM. A push and a pop in the same cycle leave `count` unchanged.
- There is no fall-through: a full FIFO deasserts `cmd_ready` even if a pop occurs that cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load `alu_a/b/sel`, load `rsp_sel`, set `cnt<=ALU_LAT`, go to WAIT.
  - WAIT: if `cnt≠0`, `cnt<=cnt-1`. If `cnt==0`, capture `rsp_data<=alu_out` and `rsp_carry<=alu_carry`, set `rsp_valid<=1`, go to HOLD.
  - HOLD: `rsp_*` stable while `rsp_valid && !rsp_ready`. On handshake: if FIFO non-empty, pop and load as in IDLE, then go to WAIT with `rsp_valid<=0`. Otherwise clear `rsp_valid` and go to IDLE.
- `alu_*` hold their last issued value until the next pop. They are never cleared except by reset.
- The result is passed through unmodified. The block applies no width or arithmetic interpretation to the result; `alu_carry` is taken as-is.
- Commands are issued in strict FIFO order. Exactly one response is produced per accepted command, and only one op is in flight at a time.

## Timing
- Reset, asynchronous and effective immediately: state=IDLE, FIFO empty, `count=0`.
  - Zero: `alu_a/b/sel`, `rsp_valid`, `rsp_data`, `rsp_carry`, `rsp_sel`, `busy`.
  - `cmd_ready`: 0 while `rst_n` is low, 1 on the first cycle after release.
- Reset mid-operation discards queued and in-flight commands. A response that has not been handshaken is lost.
- Latency, with an empty FIFO, state IDLE and `rsp_ready` held at 1:
  - Push at edge E0, pop at E1, ALU samples at E2 (`ALU_LAT=1`), capture at E(2+ALU_LAT).
  - `rsp_valid` is high `ALU_LAT+2` cycles after the push edge.
- Back-to-back throughput: one response per `ALU_LAT+2` cycles.
- Stall: while `rsp_ready=0` in HOLD, the FIFO continues to accept pushes until full. `alu_*` do not change.
- `rsp_valid` never deasserts without a handshake, except on reset.

## Structure
- Package `alu_seq_pkg` holds:
  - `ALU_SEL_W=3`.
  - typedef `alu_cmd_t` {a[N], b[N], sel[3]}, with N fixed at 32 in the package.
  - enum `seq_state_e` {IDLE, WAIT, HOLD}.
- Sub-module `alu_cmd_fifo`: synchronous FIFO with pointer wrap, full/empty and count. It has `clk`/`rst_n`, push/pop and `alu_cmd_t` data.
- The FSM and response register live in the top level.

## Test plan
The bench instantiates the real `alu` (sel 000 = add, 001 = subtract).
- Reset, then push A=0x0A, B=0x02, sel=000 with `rsp_ready=1`:
  - `rsp_valid` is high exactly 3 cycles after the push.
  - Response: `rsp_data=0x0C`, `rsp_carry=0`, `rsp_sel=000`.
- Push A=0xFFFFFFF6, B=0x0A, sel=000 → `rsp_data=0x00000000`, `rsp_carry=1`.
- Fill: with `rsp_ready=0`, push 6 commands (0x0A−k, sel=001, k=0..5):
  - The 1st is issued and held in HOLD.
  - `cmd_ready` drops after the FIFO holds 4, so `count=4`.
  - Release `rsp_ready` → 5 responses in order: 0x08, 0x07, 0x06, 0x05, 0x04.
  - The 6th is accepted once space frees.
- Backpressure: hold `rsp_ready=0` for 10 cycles → `rsp_data`, `rsp_carry`, `rsp_sel` and `alu_*` are stable throughout, and `rsp_valid` stays 1.
- Simultaneous push and pop with `count=2` at the HOLD handshake → `count` stays 2 and the next op is issued with no IDLE cycle.
- Assert `rst_n=0` asynchronously mid-WAIT with 3 commands queued:
  - Outputs go to reset values immediately.
  - After release, no stale response appears.
  - A new command returns the correct result.
